// File: rtl/analog_mux_seq.sv
// analog_mux_seq: break-before-make controller for the analog pad multiplexer.
// An asynchronous strobe issues a command (connect one design to a masked set
// of pad buses, or disconnect everything). Every change opens all switches
// first and holds them open for DEAD_CYCLES before the new set closes.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_latch      async command strobe (rising edge issues a command)
//   i_en         1 = connect, 0 = disconnect all
//   i_sel        target design index
//   i_bus_mask   per-bus connect mask for the target design
//   sw_en/_b     switch enables (bit = design*N_BUSES + bus) and complement
//   busy         dead time running or command pending
//   active       at least one switch closed
//   cur_sel      connected design index, 0 when none
//   err          last accepted command selected a non-existent design
module analog_mux_seq #(
  parameter int N_USER_MODULES = 4,
  parameter int N_BUSES        = 2,
  parameter int DEAD_CYCLES    = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_latch,
  input  logic                                i_en,
  input  logic [3:0]                          i_sel,
  input  logic [N_BUSES-1:0]                  i_bus_mask,
  output logic [N_USER_MODULES*N_BUSES-1:0]   sw_en,
  output logic [N_USER_MODULES*N_BUSES-1:0]   sw_en_b,
  output logic                                busy,
  output logic                                active,
  output logic [3:0]                          cur_sel,
  output logic                                err
);
  localparam int         NW        = N_USER_MODULES * N_BUSES;
  localparam logic [4:0] NUM_DES   = 5'(N_USER_MODULES);
  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEAD, ON} state_t;

  // Strobe synchroniser + registered rising-edge detect
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_q;
  logic                   r_cmd_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_sync_q    <= 1'b0;
      r_cmd_pulse <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], i_latch};
      r_sync_q    <= r_sync[SYNC_STAGES-1];
      r_cmd_pulse <= r_sync[SYNC_STAGES-1] & ~r_sync_q;
    end
  end

  // Command decode into a target configuration
  logic                                    w_sel_ok, w_invalid, w_connect;
  logic [N_USER_MODULES-1:0][N_BUSES-1:0]  w_row_cfg;
  logic [NW-1:0]                           w_cmd_cfg;
  logic [3:0]                              w_cmd_sel;

  assign w_sel_ok  = ({1'b0, i_sel} < NUM_DES);
  assign w_invalid = i_en & ~w_sel_ok;
  assign w_connect = i_en & w_sel_ok & (|i_bus_mask);

  generate
    for (genvar d = 0; d < N_USER_MODULES; d++) begin : g_row
      assign w_row_cfg[d] = (w_connect && (i_sel == 4'(d))) ? i_bus_mask : '0;
    end
  endgenerate

  assign w_cmd_cfg = w_row_cfg;
  assign w_cmd_sel = w_connect ? i_sel : 4'd0;

  // Sequencer state
  state_t        r_state, w_nstate;
  logic [7:0]    r_cnt, w_ncnt;
  logic [NW-1:0] r_tgt, w_ntgt, r_pend_cfg, w_npend_cfg, r_sw_en, w_nsw;
  logic [3:0]    r_tgt_sel, w_ntgt_sel, r_pend_sel, w_npend_sel, r_cur_sel, w_ncur;
  logic          r_pend_vld, w_npend_vld, r_err, w_nerr, r_busy, r_active;
  logic [NW-1:0] r_sw_en_b;
  // Pending view at the end of dead time: a command arriving in that very
  // cycle is newest, so it wins over the stored one.
  logic          w_pv;
  logic [NW-1:0] w_pcfg;
  logic [3:0]    w_psel;

  assign w_pv   = r_cmd_pulse | r_pend_vld;
  assign w_pcfg = r_cmd_pulse ? w_cmd_cfg : r_pend_cfg;
  assign w_psel = r_cmd_pulse ? w_cmd_sel : r_pend_sel;

  always_comb begin
    w_nstate    = r_state;
    w_ncnt      = r_cnt;
    w_ntgt      = r_tgt;
    w_ntgt_sel  = r_tgt_sel;
    w_npend_vld = r_pend_vld;
    w_npend_cfg = r_pend_cfg;
    w_npend_sel = r_pend_sel;
    w_nsw       = r_sw_en;
    w_ncur      = r_cur_sel;
    w_nerr      = r_err;

    if (r_cmd_pulse) begin
      if (w_invalid)                        w_nerr = 1'b1;
      else if (!(i_en && !(|i_bus_mask)))   w_nerr = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (r_cmd_pulse && (|w_cmd_cfg)) begin
          w_nstate   = DEAD;
          w_ncnt     = DEAD_LOAD;
          w_ntgt     = w_cmd_cfg;
          w_ntgt_sel = w_cmd_sel;
        end
      end
      ON: begin
        // Identical command leaves the switches untouched
        if (r_cmd_pulse && (w_cmd_cfg != r_sw_en)) begin
          w_nstate   = DEAD;
          w_ncnt     = DEAD_LOAD;
          w_ntgt     = w_cmd_cfg;
          w_ntgt_sel = w_cmd_sel;
          w_nsw      = '0;
          w_ncur     = 4'd0;
        end
      end
      DEAD: begin
        if (r_cnt == 8'd0) begin
          if (w_pv) begin
            // Restart dead time for the newer command; switches stay open
            w_ncnt      = DEAD_LOAD;
            w_ntgt      = w_pcfg;
            w_ntgt_sel  = w_psel;
            w_npend_vld = 1'b0;
          end else if (|r_tgt) begin
            w_nstate = ON;
            w_nsw    = r_tgt;
            w_ncur   = r_tgt_sel;
          end else begin
            w_nstate = IDLE;
          end
        end else begin
          w_ncnt = r_cnt - 8'd1;
          if (r_cmd_pulse) begin
            w_npend_vld = 1'b1;
            w_npend_cfg = w_cmd_cfg;
            w_npend_sel = w_cmd_sel;
          end
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tgt      <= '0;
      r_tgt_sel  <= '0;
      r_pend_vld <= 1'b0;
      r_pend_cfg <= '0;
      r_pend_sel <= '0;
      r_sw_en    <= '0;
      r_sw_en_b  <= '1;
      r_cur_sel  <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_cnt      <= w_ncnt;
      r_tgt      <= w_ntgt;
      r_tgt_sel  <= w_ntgt_sel;
      r_pend_vld <= w_npend_vld;
      r_pend_cfg <= w_npend_cfg;
      r_pend_sel <= w_npend_sel;
      r_sw_en    <= w_nsw;
      r_sw_en_b  <= ~w_nsw;
      r_cur_sel  <= w_ncur;
      r_err      <= w_nerr;
      r_busy     <= (w_nstate == DEAD) | w_npend_vld;
      r_active   <= |w_nsw;
    end
  end

  assign sw_en   = r_sw_en;
  assign sw_en_b = r_sw_en_b;
  assign busy    = r_busy;
  assign active  = r_active;
  assign cur_sel = r_cur_sel;
  assign err     = r_err;
endmodule

// File: tb/tb_analog_mux_seq.sv
// Directed bench for analog_mux_seq: default instance (4 designs, 2 buses,
// dead 4) and a corner instance (15 designs, 1 bus, dead 1). Each instance is
// held in reset while the other one is exercised.
module tb_analog_mux_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n, i_latch, i_en;
  logic [3:0]  i_sel;
  logic [1:0]  mask_a;
  logic [0:0]  mask_b;

  logic [7:0]  swa, swba;
  logic        busya, activea, erra;
  logic [3:0]  cura;
  logic [14:0] swb, swbb;
  logic        busyb, activeb, errb;
  logic [3:0]  curb;

  int n_vec = 0;
  int n_err = 0;

  analog_mux_seq u_a (
    .clk(clk), .rst_n(rst_a_n), .i_latch(i_latch), .i_en(i_en), .i_sel(i_sel),
    .i_bus_mask(mask_a), .sw_en(swa), .sw_en_b(swba), .busy(busya),
    .active(activea), .cur_sel(cura), .err(erra)
  );

  analog_mux_seq #(.N_USER_MODULES(15), .N_BUSES(1), .DEAD_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_b_n), .i_latch(i_latch), .i_en(i_en), .i_sel(i_sel),
    .i_bus_mask(mask_b), .sw_en(swb), .sw_en_b(swbb), .busy(busyb),
    .active(activeb), .cur_sel(curb), .err(errb)
  );

  // Expected values k negedges after the strobe was first sampled (edge 1):
  // command acts at edge 4, switches open for d cycles, new set at edge 4+d.
  function automatic logic [14:0] exp_sw(int k, int d, logic [14:0] o, logic [14:0] n);
    return (k < 4) ? o : ((k < 4 + d) ? 15'h0 : n);
  endfunction
  function automatic logic [3:0] exp_cur(int k, int d, logic [3:0] o, logic [3:0] n);
    return (k < 4) ? o : ((k < 4 + d) ? 4'd0 : n);
  endfunction
  function automatic logic exp_busy(int k, int d);
    return (k >= 4) && (k < 4 + d);
  endfunction
  function automatic int rows_a(logic [7:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[2*i +: 2] != 2'b00) r++;
    return r;
  endfunction

  task automatic strobe(input logic en, input logic [3:0] sel, input logic [1:0] m);
    @(negedge clk);
    i_en = en; i_sel = sel; mask_a = m; mask_b = m[0]; i_latch = 1'b1;
    @(negedge clk);
    i_latch = 1'b0;
  endtask

  task automatic test_reset;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({swa, swba, busya, activea, cura, erra} !== {8'h00, 8'hff, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_a got sw=%h swb=%h busy=%b act=%b cur=%0d err=%b", swa, swba, busya, activea, cura, erra);
    end
    n_vec++;
    if ({swb, swbb, busyb, activeb, curb, errb} !== {15'h0, 15'h7fff, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_b got sw=%h swb=%h busy=%b act=%b cur=%0d err=%b", swb, swbb, busyb, activeb, curb, errb);
    end
    rst_a_n = 1'b1;
  endtask

  // Connect design 2 from idle, then move to design 1 / bus 0
  task automatic test_connect_switch;
    logic [3:0]  sel_t [2] = '{4'd2, 4'd1};
    logic [1:0]  msk_t [2] = '{2'b11, 2'b01};
    logic [7:0]  new_t [2] = '{8'h30, 8'h04};
    logic [7:0]  old_v = 8'h00, e;
    logic [14:0] e15;
    logic [3:0]  old_c = 4'd0, ec;
    logic        eb;
    for (int s = 0; s < 2; s++) begin
      strobe(1'b1, sel_t[s], msk_t[s]);
      for (int k = 2; k <= 11; k++) begin
        @(negedge clk);
        e15 = exp_sw(k, 4, {7'b0, old_v}, {7'b0, new_t[s]});
        e = e15[7:0];
        ec = exp_cur(k, 4, old_c, sel_t[s]);
        eb = exp_busy(k, 4);
        n_vec++;
        if ({swa, swba, busya, activea, cura, erra} !== {e, ~e, eb, |e, ec, 1'b0}) begin
          n_err++;
          $display("FAIL connect_switch s=%0d k=%0d got sw=%h swb=%h busy=%b act=%b cur=%0d err=%b want sw=%h busy=%b cur=%0d",
                   s, k, swa, swba, busya, activea, cura, erra, e, eb, ec);
        end
        n_vec++;
        if (rows_a(swa) > 1) begin
          n_err++;
          $display("FAIL two_rows k=%0d got sw=%h want at most one design row", k, swa);
        end
      end
      old_v = new_t[s]; old_c = sel_t[s];
    end
  endtask

  // Identical command while ON: nothing moves
  task automatic test_same_cmd;
    strobe(1'b1, 4'd1, 2'b01);
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      n_vec++;
      if ({swa, swba, busya, cura} !== {8'h04, 8'hfb, 1'b0, 4'd1}) begin
        n_err++;
        $display("FAIL same_cmd k=%0d got sw=%h swb=%h busy=%b cur=%0d want sw=04 busy=0 cur=1", k, swa, swba, busya, cura);
      end
    end
  endtask

  // Out-of-range select opens and sets err; a valid command clears it
  task automatic test_invalid;
    logic [14:0] e15;
    logic [7:0]  e;
    logic        ee;
    strobe(1'b1, 4'd5, 2'b11);
    for (int k = 2; k <= 11; k++) begin
      @(negedge clk);
      e15 = exp_sw(k, 4, 15'h04, 15'h0); e = e15[7:0];
      ee = (k >= 4);
      n_vec++;
      if ({swa, busya, cura, erra} !== {e, exp_busy(k, 4), exp_cur(k, 4, 4'd1, 4'd0), ee}) begin
        n_err++;
        $display("FAIL invalid_sel k=%0d got sw=%h busy=%b cur=%0d err=%b want sw=%h err=%b", k, swa, busya, cura, erra, e, ee);
      end
    end
    strobe(1'b1, 4'd0, 2'b10);
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      e15 = exp_sw(k, 4, 15'h0, 15'h02); e = e15[7:0];
      ee = (k < 4);
      n_vec++;
      if ({swa, swba, activea, erra} !== {e, ~e, |e, ee}) begin
        n_err++;
        $display("FAIL err_clear k=%0d got sw=%h swb=%h act=%b err=%b want sw=%h err=%b", k, swa, swba, activea, erra, e, ee);
      end
    end
  endtask

  // Two commands during dead time: last wins, dead time restarts
  task automatic test_back_to_back;
    logic [14:0] e15;
    logic [7:0]  e;
    logic        eb;
    @(negedge clk);
    i_en = 1'b1; i_sel = 4'd3; mask_a = 2'b11; mask_b = 1'b1; i_latch = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e15 = exp_sw(k, 8, 15'h02, 15'h01); e = e15[7:0];
        eb = exp_busy(k, 8);
        n_vec++;
        if ({swa, swba, busya, activea} !== {e, ~e, eb, |e}) begin
          n_err++;
          $display("FAIL back_to_back k=%0d got sw=%h swb=%h busy=%b act=%b want sw=%h busy=%b", k, swa, swba, busya, activea, e, eb);
        end
        n_vec++;
        if (swa[7:6] !== 2'b00) begin
          n_err++;
          $display("FAIL overwritten_closed k=%0d got sw=%h want design 3 open", k, swa);
        end
      end
      case (k)
        1: i_latch = 1'b0;
        2: i_latch = 1'b1;
        3: i_latch = 1'b0;
        4: begin i_sel = 4'd0; mask_a = 2'b01; mask_b = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid;
    // Mid-dead with a pending command
    @(negedge clk);
    i_en = 1'b1; i_sel = 4'd2; mask_a = 2'b11; i_latch = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      case (k)
        1: i_latch = 1'b0;
        2: i_latch = 1'b1;
        3: i_latch = 1'b0;
        4: i_sel = 4'd3;
        default: ;
      endcase
    end
    n_vec++;
    if ({swa, busya} !== {8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset_dead got sw=%h busy=%b want sw=00 busy=1", swa, busya);
    end
    #2 rst_a_n = 1'b0;
    #1;
    n_vec++;
    if ({swa, swba, busya, activea, cura, erra} !== {8'h00, 8'hff, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_dead got sw=%h swb=%h busy=%b act=%b cur=%0d", swa, swba, busya, activea, cura);
    end
    @(negedge clk); rst_a_n = 1'b1;
    repeat (14) @(negedge clk);
    n_vec++;
    if ({swa, busya, cura} !== {8'h00, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL pending_dropped got sw=%h busy=%b cur=%0d want all idle", swa, busya, cura);
    end
    // Mid-on
    strobe(1'b1, 4'd1, 2'b11);
    repeat (8) @(negedge clk);
    n_vec++;
    if ({swa, cura} !== {8'h0c, 4'd1}) begin
      n_err++;
      $display("FAIL pre_reset_on got sw=%h cur=%0d want sw=0c cur=1", swa, cura);
    end
    #2 rst_a_n = 1'b0;
    #1;
    n_vec++;
    if ({swa, swba, activea, cura} !== {8'h00, 8'hff, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL reset_mid_on got sw=%h swb=%h act=%b cur=%0d", swa, swba, activea, cura);
    end
  endtask

  // Corner instance: 15 designs, 1 bus, single dead cycle, sel 15 invalid
  task automatic test_small_dut;
    logic [3:0]  sel_t [4] = '{4'd14, 4'd7, 4'd15, 4'd3};
    logic [14:0] new_t [4] = '{15'h4000, 15'h0080, 15'h0000, 15'h0008};
    logic [3:0]  cur_t [4] = '{4'd14, 4'd7, 4'd0, 4'd3};
    logic        err_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [14:0] old_v = 15'h0, e;
    logic [3:0]  old_c = 4'd0, ec;
    logic        old_e = 1'b0, ee;
    @(negedge clk); rst_b_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      strobe(1'b1, sel_t[s], 2'b01);
      for (int k = 2; k <= 7; k++) begin
        @(negedge clk);
        e  = exp_sw(k, 1, old_v, new_t[s]);
        ec = exp_cur(k, 1, old_c, cur_t[s]);
        ee = (k >= 4) ? err_t[s] : old_e;
        n_vec++;
        if ({swb, swbb, busyb, activeb, curb, errb} !== {e, ~e, exp_busy(k, 1), |e, ec, ee}) begin
          n_err++;
          $display("FAIL small_seq s=%0d k=%0d got sw=%h swb=%h busy=%b act=%b cur=%0d err=%b want sw=%h cur=%0d err=%b",
                   s, k, swb, swbb, busyb, activeb, curb, errb, e, ec, ee);
        end
      end
      old_v = new_t[s]; old_c = cur_t[s]; old_e = err_t[s];
    end
    // Reset mid-dead after an invalid command
    strobe(1'b1, 4'd15, 2'b01);
    repeat (3) @(negedge clk);
    n_vec++;
    if ({swb, busyb, errb} !== {15'h0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL small_pre_reset got sw=%h busy=%b err=%b want sw=0 busy=1 err=1", swb, busyb, errb);
    end
    #2 rst_b_n = 1'b0;
    #1;
    n_vec++;
    if ({swb, swbb, busyb, activeb, curb, errb} !== {15'h0, 15'h7fff, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL small_reset_dead got sw=%h swb=%h busy=%b act=%b cur=%0d err=%b", swb, swbb, busyb, activeb, curb, errb);
    end
    @(negedge clk); rst_b_n = 1'b1;
    strobe(1'b1, 4'd5, 2'b01);
    repeat (5) @(negedge clk);
    n_vec++;
    if ({swb, curb} !== {15'h0020, 4'd5}) begin
      n_err++;
      $display("FAIL small_pre_reset_on got sw=%h cur=%0d want sw=0020 cur=5", swb, curb);
    end
    #2 rst_b_n = 1'b0;
    #1;
    n_vec++;
    if ({swb, swbb, activeb, curb} !== {15'h0, 15'h7fff, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL small_reset_on got sw=%h swb=%h act=%b cur=%0d", swb, swbb, activeb, curb);
    end
  endtask

  initial begin
    i_latch = 1'b0; i_en = 1'b0; i_sel = 4'd0; mask_a = 2'b00; mask_b = 1'b0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    test_reset;
    test_connect_switch;
    test_same_cmd;
    test_invalid;
    test_back_to_back;
    test_reset_mid;
    test_small_dut;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
